// File: rtl/bpuf_pkg.sv
// bpuf_pkg: shared state encoding and constants for the BPUF evaluation sequencer
package bpuf_pkg;
  typedef enum logic [2:0] {
    IDLE,
    EXCITE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;
  localparam int MIN_SETTLE = 3;
endpackage

// File: rtl/bpuf_vote_cell.sv
// bpuf_vote_cell: synchronizes one BPUF Q output and majority-votes it across repetitions
module bpuf_vote_cell
  import bpuf_pkg::*;
#(
  parameter int NUM_EVALS = 7,
  localparam int CW = $clog2(NUM_EVALS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  input  logic clr,
  input  logic acc,
  output logic maj,
  output logic unstable
);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] ones_q, ones_d;
  // two-flop synchronizer and saturating ones counter
  always_comb begin
    sync_d = {sync_q[0], q_in};
    ones_d = clr ? '0 : (acc && ones_q != CW'(NUM_EVALS)) ? ones_q + CW'(sync_q[1]) : ones_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      ones_q <= '0;
    end else begin
      sync_q <= sync_d;
      ones_q <= ones_d;
    end
  end
  assign maj      = (2 * int'(ones_q)) > NUM_EVALS;
  assign unstable = ones_q != '0 && ones_q != CW'(NUM_EVALS);
endmodule

// File: rtl/bpuf_eval_ctrl.sv
// bpuf_eval_ctrl: excite/settle/sample sequencer with per-cell majority voting for a BPUF array
module bpuf_eval_ctrl
  import bpuf_pkg::*;
#(
  parameter int NUM_CELLS     = 8,
  parameter int NUM_EVALS     = 7,
  parameter int EXCITE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] cell_en,
  output logic                 busy,
  output logic [NUM_CELLS-1:0] excite,
  input  logic [NUM_CELLS-1:0] q_in,
  output logic [NUM_CELLS-1:0] resp_data,
  output logic [NUM_CELLS-1:0] resp_unstable,
  output logic                 resp_valid,
  input  logic                 resp_ready
);
  localparam int MAXP = EXCITE_CYCLES > SETTLE_CYCLES ? EXCITE_CYCLES : SETTLE_CYCLES;
  localparam int PW   = MAXP > 1 ? $clog2(MAXP) : 1;
  localparam int EW   = $clog2(NUM_EVALS + 1);
  if (NUM_CELLS < 1 || NUM_CELLS > 64 || NUM_EVALS < 1 || NUM_EVALS % 2 == 0 ||
      EXCITE_CYCLES < 1 || SETTLE_CYCLES < MIN_SETTLE) begin : g_bad_param
    $error("bpuf_eval_ctrl: illegal parameter set");
  end
  state_e               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [EW-1:0]        eval_q, eval_d;
  logic [NUM_CELLS-1:0] en_q, en_d;
  logic [NUM_CELLS-1:0] excite_q, excite_d;
  logic [NUM_CELLS-1:0] data_q, data_d;
  logic [NUM_CELLS-1:0] unst_q, unst_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 clr, capture;
  logic [NUM_CELLS-1:0] acc, maj, unst;
  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    bpuf_vote_cell #(.NUM_EVALS(NUM_EVALS)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .q_in     (q_in[i]),
      .clr      (clr),
      .acc      (acc[i]),
      .maj      (maj[i]),
      .unstable (unst[i])
    );
  end
  // sequencer next state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    eval_d  = eval_q;
    en_d    = en_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = EXCITE;
        en_d    = cell_en;
        phase_d = '0;
        eval_d  = '0;
        clr     = 1'b1;
      end
      EXCITE: begin
        state_d = phase_q == PW'(EXCITE_CYCLES - 1) ? SETTLE : EXCITE;
        phase_d = phase_q == PW'(EXCITE_CYCLES - 1) ? '0 : phase_q + 1'b1;
      end
      SETTLE: begin
        state_d = phase_q == PW'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE;
        phase_d = phase_q == PW'(SETTLE_CYCLES - 1) ? '0 : phase_q + 1'b1;
      end
      SAMPLE: begin
        eval_d  = eval_q + 1'b1;
        state_d = eval_q == EW'(NUM_EVALS - 1) ? DONE : EXCITE;
      end
      DONE: state_d = (resp_valid_q && resp_ready) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    acc          = state_q == SAMPLE ? en_q : '0;
    excite_d     = state_q == EXCITE ? en_q : '0;
    capture      = state_q == DONE && !resp_valid_q;
    data_d       = capture ? maj & en_q : data_q;
    unst_d       = capture ? unst & en_q : unst_q;
    resp_valid_d = state_q == DONE && !(resp_valid_q && resp_ready);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      eval_q       <= '0;
      en_q         <= '0;
      excite_q     <= '0;
      data_q       <= '0;
      unst_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      eval_q       <= eval_d;
      en_q         <= en_d;
      excite_q     <= excite_d;
      data_q       <= data_d;
      unst_q       <= unst_d;
      resp_valid_q <= resp_valid_d;
    end
  end
  assign busy          = state_q != IDLE;
  assign excite        = excite_q;
  assign resp_data     = data_q;
  assign resp_unstable = unst_q;
  assign resp_valid    = resp_valid_q;
endmodule
